// File: rtl/trace_loader_pkg.sv
// Shared definitions for the trace rule loader: FSM states and the
// trace register map (offsets mirror defines_trace.v).
package trace_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAT,
        ST_MSK,
        ST_EN_RD,
        ST_EN_WR,
        ST_TEN_RD,
        ST_TEN_WR,
        ST_DONE
    } state_t;

    localparam int DEF_BUFFER_SIZE = 64;
    localparam int NBYTES          = DEF_BUFFER_SIZE / 8;

    // Block select sitting just above the 5-bit register offset.
    localparam logic [1:0] TRACE_REG_SELECT = 2'b11;

    localparam logic [4:0] TRACE_NAME                = 5'h00;
    localparam logic [4:0] TRACE_PATTERN_ENABLE      = 5'h01;
    localparam logic [4:0] TRACE_PATTERN_TRIG_ENABLE = 5'h02;

    // Per-rule pattern register offsets; the map is split into two banks,
    // so the offset is looked up rather than computed as base+rule.
    function automatic logic [4:0] pattern_addr(input int rule);
        case (rule)
            0:       return 5'h04;
            1:       return 5'h05;
            2:       return 5'h06;
            3:       return 5'h07;
            4:       return 5'h10;
            5:       return 5'h11;
            6:       return 5'h12;
            7:       return 5'h13;
            default: return 5'h1F;
        endcase
    endfunction

    // Per-rule mask register offsets.
    function automatic logic [4:0] mask_addr(input int rule);
        case (rule)
            0:       return 5'h08;
            1:       return 5'h09;
            2:       return 5'h0A;
            3:       return 5'h0B;
            4:       return 5'h14;
            5:       return 5'h15;
            6:       return 5'h16;
            7:       return 5'h17;
            default: return 5'h1F;
        endcase
    endfunction

endpackage

// File: rtl/trace_loader_bus_mux.sv
// Host/loader register bus mux. The host always wins, with zero latency;
// the loader only gets cycles the host leaves idle. Also flags host writes
// into trace register space while a load is running.
module trace_loader_bus_mux
    import trace_loader_pkg::*;
#(
    parameter int AW = 14,
    parameter int BW = 7
)(
    input  logic [AW-1:0] i_host_address,
    input  logic [BW-1:0] i_host_bytecnt,
    input  logic [7:0]    i_host_write_data,
    input  logic          i_host_read,
    input  logic          i_host_write,
    input  logic          i_host_addrvalid,
    input  logic          i_lo_act,
    input  logic [AW-1:0] i_lo_address,
    input  logic [BW-1:0] i_lo_bytecnt,
    input  logic [7:0]    i_lo_write_data,
    input  logic          i_lo_read,
    input  logic          i_lo_write,
    input  logic          i_busy,
    output logic [AW-1:0] o_reg_address,
    output logic [BW-1:0] o_reg_bytecnt,
    output logic [7:0]    o_write_data,
    output logic          o_reg_read,
    output logic          o_reg_write,
    output logic          o_reg_addrvalid,
    output logic          o_coll_hit
);

    logic w_lo_own;
    logic w_trace_hit;

    assign w_lo_own    = i_lo_act && !i_host_addrvalid;
    assign w_trace_hit = (i_host_address >> 5) == AW'(TRACE_REG_SELECT);
    assign o_coll_hit  = i_host_write && i_host_addrvalid && w_trace_hit && i_busy;

    // Select loader fields only when it owns the cycle, else pass the host through.
    always_comb begin
        o_reg_address   = i_host_address;
        o_reg_bytecnt   = i_host_bytecnt;
        o_write_data    = i_host_write_data;
        o_reg_read      = i_host_read;
        o_reg_write     = i_host_write;
        o_reg_addrvalid = i_host_addrvalid;
        if (w_lo_own) begin
            o_reg_address   = i_lo_address;
            o_reg_bytecnt   = i_lo_bytecnt;
            o_write_data    = i_lo_write_data;
            o_reg_read      = i_lo_read;
            o_reg_write     = i_lo_write;
            o_reg_addrvalid = 1'b1;
        end
    end

endmodule

// File: rtl/trace_rule_loader.sv
// Programs one trace match rule (pattern, mask, enable bits) into the trace
// register block by stealing idle host bus cycles.
module trace_rule_loader
    import trace_loader_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pBUFFER_SIZE  = 64,
    parameter int pMATCH_RULES  = 8
)(
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] host_address,
    input  logic [pBYTECNT_SIZE-1:0]             host_bytecnt,
    input  logic [7:0]                           host_write_data,
    input  logic                                 host_read,
    input  logic                                 host_write,
    input  logic                                 host_addrvalid,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           write_data,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid,
    input  logic [7:0]                           read_data,
    input  logic                                 I_req_valid,
    output logic                                 O_req_ready,
    input  logic [$clog2(pMATCH_RULES)-1:0]      I_req_rule,
    input  logic [pBUFFER_SIZE-1:0]              I_req_pattern,
    input  logic [pBUFFER_SIZE-1:0]              I_req_mask,
    input  logic                                 I_req_enable,
    input  logic                                 I_req_trig_enable,
    output logic                                 O_busy,
    output logic                                 O_done,
    output logic                                 O_collision
);

    localparam int AW  = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int NB  = pBUFFER_SIZE / 8;
    localparam int RW  = $clog2(pMATCH_RULES);
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BCW-1:0] BC_LAST = BCW'(NB - 1);

    state_t                   r_state, w_state_nxt;
    logic [BCW-1:0]           r_bc;
    logic [RW-1:0]            r_rule;
    logic [pBUFFER_SIZE-1:0]  r_pattern, r_mask;
    logic                     r_en, r_ten, r_collision;
    logic [7:0]               r_shadow, w_shadow_mod;

    logic                     w_accept, w_go, w_bc_last, w_coll_hit;
    logic                     w_lo_act, w_lo_read, w_lo_write;
    logic [4:0]               w_lo_off;
    logic [AW-1:0]            w_lo_addr;
    logic [pBYTECNT_SIZE-1:0] w_lo_bytecnt;
    logic [7:0]               w_lo_wdata;

    // Ready is gated by reset so it reads 0 while reset is held.
    assign O_req_ready = (r_state == ST_IDLE) && reset_n;
    assign O_busy      = (r_state != ST_IDLE);
    assign O_done      = (r_state == ST_DONE);
    assign O_collision = r_collision;
    assign w_accept    = I_req_valid && O_req_ready;
    assign w_go        = !host_addrvalid;
    assign w_bc_last   = (r_bc == BC_LAST);
    assign w_lo_addr   = AW'({TRACE_REG_SELECT, w_lo_off});

    // Next state and the loader's bus request for the current state.
    always_comb begin
        w_state_nxt  = r_state;
        w_lo_act     = 1'b0;
        w_lo_off     = '0;
        w_lo_bytecnt = '0;
        w_lo_wdata   = '0;
        w_lo_read    = 1'b0;
        w_lo_write   = 1'b0;
        w_shadow_mod = r_shadow;
        w_shadow_mod[r_rule] = (r_state == ST_TEN_WR) ? r_ten : r_en;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_PAT;
            ST_PAT: begin
                w_lo_act     = 1'b1;
                w_lo_off     = pattern_addr(int'(r_rule));
                w_lo_bytecnt = pBYTECNT_SIZE'(r_bc);
                w_lo_wdata   = r_pattern[{r_bc, 3'b000} +: 8];
                w_lo_write   = 1'b1;
                if (w_go && w_bc_last) w_state_nxt = ST_MSK;
            end
            ST_MSK: begin
                w_lo_act     = 1'b1;
                w_lo_off     = mask_addr(int'(r_rule));
                w_lo_bytecnt = pBYTECNT_SIZE'(r_bc);
                w_lo_wdata   = r_mask[{r_bc, 3'b000} +: 8];
                w_lo_write   = 1'b1;
                if (w_go && w_bc_last) w_state_nxt = ST_EN_RD;
            end
            ST_EN_RD: begin
                w_lo_act  = 1'b1;
                w_lo_off  = TRACE_PATTERN_ENABLE;
                w_lo_read = 1'b1;
                if (w_go) w_state_nxt = ST_EN_WR;
            end
            ST_EN_WR: begin
                // A host cycle here may have changed the register: re-read.
                w_lo_act    = 1'b1;
                w_lo_off    = TRACE_PATTERN_ENABLE;
                w_lo_wdata  = w_shadow_mod;
                w_lo_write  = 1'b1;
                w_state_nxt = w_go ? ST_TEN_RD : ST_EN_RD;
            end
            ST_TEN_RD: begin
                w_lo_act  = 1'b1;
                w_lo_off  = TRACE_PATTERN_TRIG_ENABLE;
                w_lo_read = 1'b1;
                if (w_go) w_state_nxt = ST_TEN_WR;
            end
            ST_TEN_WR: begin
                w_lo_act    = 1'b1;
                w_lo_off    = TRACE_PATTERN_TRIG_ENABLE;
                w_lo_wdata  = w_shadow_mod;
                w_lo_write  = 1'b1;
                w_state_nxt = w_go ? ST_DONE : ST_TEN_RD;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any load in progress.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Request capture, byte counter, RMW shadow and sticky collision flag.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bc        <= '0;
            r_rule      <= '0;
            r_pattern   <= '0;
            r_mask      <= '0;
            r_en        <= 1'b0;
            r_ten       <= 1'b0;
            r_shadow    <= '0;
            r_collision <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rule      <= I_req_rule;
                r_pattern   <= I_req_pattern;
                r_mask      <= I_req_mask;
                r_en        <= I_req_enable;
                r_ten       <= I_req_trig_enable;
                r_bc        <= '0;
                r_collision <= 1'b0;
            end else if (w_coll_hit) begin
                r_collision <= 1'b1;
            end
            if ((r_state == ST_PAT || r_state == ST_MSK) && w_go)
                r_bc <= w_bc_last ? '0 : r_bc + BCW'(1);
            if ((r_state == ST_EN_RD || r_state == ST_TEN_RD) && w_go)
                r_shadow <= read_data;
        end
    end

    trace_loader_bus_mux #(
        .AW (AW),
        .BW (pBYTECNT_SIZE)
    ) u_mux (
        .i_host_address    (host_address),
        .i_host_bytecnt    (host_bytecnt),
        .i_host_write_data (host_write_data),
        .i_host_read       (host_read),
        .i_host_write      (host_write),
        .i_host_addrvalid  (host_addrvalid),
        .i_lo_act          (w_lo_act),
        .i_lo_address      (w_lo_addr),
        .i_lo_bytecnt      (w_lo_bytecnt),
        .i_lo_write_data   (w_lo_wdata),
        .i_lo_read         (w_lo_read),
        .i_lo_write        (w_lo_write),
        .i_busy            (O_busy),
        .o_reg_address     (reg_address),
        .o_reg_bytecnt     (reg_bytecnt),
        .o_write_data      (write_data),
        .o_reg_read        (reg_read),
        .o_reg_write       (reg_write),
        .o_reg_addrvalid   (reg_addrvalid),
        .o_coll_hit        (w_coll_hit)
    );

endmodule

// File: tb/tb_trace_rule_loader.sv
// Bench for trace_rule_loader: fake trace register block, directed scenarios
// and randomized loads under random host traffic, checked against a simple
// register-content and latency model.
module tb_trace_rule_loader;
    import trace_loader_pkg::*;

    localparam int AW = 14;
    localparam int BW = 7;
    localparam int RW = 3;

    logic          usb_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] host_address = '0;
    logic [BW-1:0] host_bytecnt = '0;
    logic [7:0]    host_write_data = '0;
    logic          host_read = 1'b0, host_write = 1'b0, host_addrvalid = 1'b0;
    logic [AW-1:0] reg_address;
    logic [BW-1:0] reg_bytecnt;
    logic [7:0]    write_data, read_data;
    logic          reg_read, reg_write, reg_addrvalid;
    logic          I_req_valid = 1'b0;
    logic [RW-1:0] I_req_rule = '0;
    logic [63:0]   I_req_pattern = '0, I_req_mask = '0;
    logic          I_req_enable = 1'b0, I_req_trig_enable = 1'b0;
    logic          O_req_ready, O_busy, O_done, O_collision;

    int n_chk = 0, n_err = 0;
    int cyc = 0, n_acc = 0, n_done = 0, n_hbusy = 0, n_enrd = 0;
    int acc_cyc = 0, done_cyc = 0;
    int acc_q[$], done_q[$];
    int pat_edge [8];
    bit rand_host = 1'b0;
    logic [7:0] exp_en = 8'h00, exp_ten = 8'h00;

    // Fake trace register block: byte array per 5-bit offset.
    logic [7:0] mem [0:31][0:7] = '{default: 8'h00};

    trace_rule_loader dut (
        .usb_clk(usb_clk), .reset_n(reset_n),
        .host_address(host_address), .host_bytecnt(host_bytecnt),
        .host_write_data(host_write_data), .host_read(host_read),
        .host_write(host_write), .host_addrvalid(host_addrvalid),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .write_data(write_data), .reg_read(reg_read), .reg_write(reg_write),
        .reg_addrvalid(reg_addrvalid), .read_data(read_data),
        .I_req_valid(I_req_valid), .O_req_ready(O_req_ready),
        .I_req_rule(I_req_rule), .I_req_pattern(I_req_pattern),
        .I_req_mask(I_req_mask), .I_req_enable(I_req_enable),
        .I_req_trig_enable(I_req_trig_enable), .O_busy(O_busy),
        .O_done(O_done), .O_collision(O_collision)
    );

    always #5 usb_clk = ~usb_clk;
    always @(posedge usb_clk) cyc <= cyc + 1;

    always @(posedge usb_clk)
        if (reg_addrvalid && reg_write && (reg_address >> 5) == AW'(TRACE_REG_SELECT))
            mem[reg_address[4:0]][reg_bytecnt[2:0]] <= write_data;
    assign read_data = mem[reg_address[4:0]][reg_bytecnt[2:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: handshakes, loader bus activity, host pass-through.
    always @(negedge usb_clk) begin
        if (I_req_valid && O_req_ready) begin n_acc++; acc_cyc = cyc + 1; acc_q.push_back(cyc + 1); end
        if (O_done) begin n_done++; done_cyc = cyc + 1; done_q.push_back(cyc + 1); end
        if (O_busy && !O_done && host_addrvalid) n_hbusy++;
        if (reg_addrvalid && !host_addrvalid && reg_write && reg_address[4:0] == pattern_addr(int'(I_req_rule)))
            pat_edge[reg_bytecnt[2:0]] = cyc + 1;
        if (reg_addrvalid && !host_addrvalid && reg_read && reg_address[4:0] == TRACE_PATTERN_ENABLE)
            n_enrd++;
        if (host_addrvalid || !O_busy)
            chk("passthru", {reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid},
                {host_address, host_bytecnt, host_write_data, host_read, host_write, host_addrvalid});
    end

    task automatic host_idle();
        host_addrvalid = 1'b0; host_read = 1'b0; host_write = 1'b0;
        host_address = '0; host_bytecnt = '0; host_write_data = '0;
    endtask

    task automatic tick();
        @(posedge usb_clk); #1;
        if (rand_host) begin
            if ($urandom_range(0, 3) == 0) begin
                host_addrvalid  = 1'b1;
                host_bytecnt    = BW'($urandom_range(0, 7));
                host_write_data = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    host_write = 1'b1; host_read = 1'b0;
                    host_address = AW'(32'h100 | $urandom_range(0, 255));
                end else begin
                    host_write = 1'b0; host_read = 1'b1;
                    host_address = ($urandom_range(0, 1) == 1) ?
                        AW'({TRACE_REG_SELECT, 5'($urandom_range(0, 31))}) :
                        AW'(32'h200 | $urandom_range(0, 255));
                end
            end else host_idle();
        end
    endtask

    task automatic host_wr(input logic [4:0] off, input logic [7:0] d);
        host_address = AW'({TRACE_REG_SELECT, off}); host_bytecnt = '0;
        host_write_data = d; host_write = 1'b1; host_read = 1'b0; host_addrvalid = 1'b1;
        tick();
        host_idle();
    endtask

    task automatic start_req(input logic [RW-1:0] r, input logic [63:0] p, input logic [63:0] m,
                             input logic e, input logic t, output int t0);
        int a0;
        a0 = n_acc;
        I_req_rule = r; I_req_pattern = p; I_req_mask = m;
        I_req_enable = e; I_req_trig_enable = t; I_req_valid = 1'b1;
        for (int i = 0; i < 100 && n_acc == a0; i++) tick();
        I_req_valid = 1'b0;
        chk("accept", n_acc - a0, 1);
        t0 = acc_cyc;
    endtask

    task automatic wait_done(input int t0, output int lat);
        int d0;
        d0 = n_done;
        for (int i = 0; i < 200 && n_done == d0; i++) tick();
        chk("done_seen", n_done - d0, 1);
        lat = done_cyc - t0;
        chk("ready_after_done", O_req_ready, 1'b1);
    endtask

    function automatic logic [63:0] rd64(input logic [4:0] off);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[b*8 +: 8] = mem[off][b];
        return v;
    endfunction

    // Model: expected register contents after a completed load.
    task automatic check_load(input logic [RW-1:0] r, input logic [63:0] p, input logic [63:0] m,
                              input logic e, input logic t);
        exp_en[r]  = e;
        exp_ten[r] = t;
        chk("pattern", rd64(pattern_addr(int'(r))), p);
        chk("mask", rd64(mask_addr(int'(r))), m);
        chk("pat_en", mem[TRACE_PATTERN_ENABLE][0], exp_en);
        chk("trig_en", mem[TRACE_PATTERN_TRIG_ENABLE][0], exp_ten);
    endtask

    initial begin
        int t0, lat, e0, d0, a0, h0;
        logic [RW-1:0] r;
        logic [63:0] p, m;
        logic e, t;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", O_req_ready, 1'b0);
        chk("rst_busy", O_busy, 1'b0);
        chk("rst_done", O_done, 1'b0);
        chk("rst_coll", O_collision, 1'b0);
        reset_n = 1'b1; #1;
        chk("rel_ready", O_req_ready, 1'b1);

        host_wr(TRACE_NAME, 8'h5A);
        host_wr(TRACE_PATTERN_ENABLE, 8'h05);
        host_wr(TRACE_PATTERN_TRIG_ENABLE, 8'h00);
        exp_en = 8'h05; exp_ten = 8'h00;

        // Idle host, rule 3
        start_req(3'd3, 64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 1'b1, 1'b1, t0);
        wait_done(t0, lat);
        chk("lat_idle", lat, 21);
        chk("pat_b0_edge", pat_edge[0] - t0, 1);
        chk("pat_b7_edge", pat_edge[7] - t0, 8);
        check_load(3'd3, 64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 1'b1, 1'b1);
        chk("pat_en_0d", mem[TRACE_PATTERN_ENABLE][0], 8'h0D);

        // Host reads the name register at T+4 and T+5
        p = {$urandom, $urandom}; m = {$urandom, $urandom};
        start_req(3'd6, p, m, 1'b0, 1'b1, t0);
        repeat (3) tick();
        host_address = AW'({TRACE_REG_SELECT, TRACE_NAME}); host_bytecnt = '0;
        host_read = 1'b1; host_addrvalid = 1'b1; #1;
        chk("host_rd_a", read_data, 8'h5A);
        tick(); #1;
        chk("host_rd_b", read_data, 8'h5A);
        tick();
        host_idle();
        wait_done(t0, lat);
        chk("lat_stall2", lat, 23);
        for (int k = 0; k < 8; k++) chk("pat_edge", pat_edge[k] - t0, (k < 3) ? k + 1 : k + 3);
        check_load(3'd6, p, m, 1'b0, 1'b1);

        // Host write to PATTERN_ENABLE in the EN_WR slot forces a re-read
        e0 = n_enrd;
        p = {$urandom, $urandom}; m = {$urandom, $urandom};
        start_req(3'd2, p, m, 1'b1, 1'b0, t0);
        repeat (17) tick();
        host_wr(TRACE_PATTERN_ENABLE, 8'hF0);
        wait_done(t0, lat);
        chk("lat_reread", lat, 23);
        chk("en_reads", n_enrd - e0, 2);
        exp_en = 8'hF0;
        check_load(3'd2, p, m, 1'b1, 1'b0);
        chk("pat_en_f4", mem[TRACE_PATTERN_ENABLE][0], 8'hF4);

        // Host write to the rule's mask during PAT sets the sticky collision
        p = {$urandom, $urandom}; m = {$urandom, $urandom};
        start_req(3'd5, p, m, 1'b1, 1'b1, t0);
        chk("coll_clr_accept", O_collision, 1'b0);
        repeat (2) tick();
        host_wr(mask_addr(5), 8'h77);
        chk("coll_set", O_collision, 1'b1);
        wait_done(t0, lat);
        chk("lat_coll", lat, 22);
        chk("coll_hold", O_collision, 1'b1);
        check_load(3'd5, p, m, 1'b1, 1'b1);

        // Reset during a load aborts without O_done
        p = {$urandom, $urandom}; m = {$urandom, $urandom};
        start_req(3'd1, p, m, 1'b1, 1'b1, t0);
        chk("coll_clr_next", O_collision, 1'b0);
        repeat (9) tick();
        d0 = n_done;
        reset_n = 1'b0; #1;
        chk("abort_busy", O_busy, 1'b0);
        chk("abort_ready", O_req_ready, 1'b0);
        repeat (3) tick();
        reset_n = 1'b1; #1;
        chk("abort_rel_ready", O_req_ready, 1'b1);
        repeat (25) tick();
        chk("abort_no_done", n_done - d0, 0);
        start_req(3'd1, p, m, 1'b1, 1'b1, t0);
        wait_done(t0, lat);
        chk("lat_after_rst", lat, 21);
        check_load(3'd1, p, m, 1'b1, 1'b1);

        // Valid held high: one accept per load, ready gap after DONE
        a0 = n_acc; d0 = n_done;
        I_req_rule = 3'd4; I_req_pattern = {$urandom, $urandom}; I_req_mask = {$urandom, $urandom};
        I_req_enable = 1'b1; I_req_trig_enable = 1'b0; I_req_valid = 1'b1;
        for (int i = 0; i < 200 && n_acc < a0 + 2; i++) tick();
        I_req_valid = 1'b0;
        chk("held_accepts", n_acc - a0, 2);
        if (n_acc >= a0 + 2 && n_done > d0) begin
            chk("held_lat", done_q[d0] - acc_q[a0], 21);
            chk("held_gap", acc_q[a0 + 1] - done_q[d0], 1);
        end
        wait_done(acc_cyc, lat);
        chk("held_lat2", lat, 21);
        chk("held_no_extra", n_acc - a0, 2);
        check_load(3'd4, I_req_pattern, I_req_mask, 1'b1, 1'b0);

        // Randomized loads under random host traffic
        rand_host = 1'b1;
        for (int n = 0; n < 25; n++) begin
            r = RW'($urandom_range(0, 7));
            p = {$urandom, $urandom}; m = {$urandom, $urandom};
            e = 1'($urandom); t = 1'($urandom);
            h0 = n_hbusy;
            start_req(r, p, m, e, t, t0);
            wait_done(t0, lat);
            chk("rnd_lat_lo", (lat >= 21 + (n_hbusy - h0)), 1'b1);
            chk("rnd_lat_hi", (lat <= 21 + 2 * (n_hbusy - h0)), 1'b1);
            chk("rnd_coll", O_collision, 1'b0);
            check_load(r, p, m, e, t);
        end
        rand_host = 1'b0;
        host_idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
